// File: rtl/ripple_carry_adder_4bit_pkg.sv
// Purpose : shared datapath constants for the small registered adder.
// Latency : n/a (constants only).
// Backpressure: n/a.
package ripple_carry_adder_4bit_pkg;

    // Default operand width; the adder is built and verified at this size.
    localparam int unsigned ADDER_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_4bit_full_adder.sv
// Purpose : 1-bit full adder, one stage of the ripple chain.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : a, b, cin -> s (sum bit), cout (carry to next stage).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// Purpose : registered unsigned adder, {cout,sum} = a + b + cin, via ripple chain.
// Latency : 1 cycle; inputs sampled on a rising edge appear after that edge.
// Backpressure: none; accepts new operands every cycle, no handshake.
// Ports   : clk, rst_n (async active-low), a/b/cin operands, sum/cout registered result.
module ripple_carry_adder_4bit
    import ripple_carry_adder_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Output register isolates downstream logic from ripple glitches.
    // Reset clears immediately; any in-flight result is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
module tb_ripple_carry_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {cout,sum} and a label, pushed when stimulus is applied.
    logic [4:0] exp_q[$];
    string      name_q[$];

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual={cout,sum}=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply operands for the next rising edge and record the expected result.
    task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                         input logic [4:0] e, input string nm);
        @(negedge clk);
        a   = ta;
        b   = tb;
        cin = tc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one result per rising edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            logic [4:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {cout, sum}, e);
        end
    end

    initial begin
        rst_n = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;

        // Reset with max inputs and clock running: outputs stay 0.
        #1 rst_n = 1'b0;
        #1 check("reset_async", {cout, sum}, 5'b0_0000);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", {cout, sum}, 5'b0_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(5'b1_1111);
        name_q.push_back("reset_release");

        // Directed vectors.
        drive(4'b0000, 4'b0000, 1'b0, 5'b0_0000, "vec_zero");
        drive(4'b0101, 4'b0011, 1'b0, 5'b0_1000, "vec_5p3");
        drive(4'b1111, 4'b0001, 1'b0, 5'b1_0000, "vec_wrap");
        drive(4'b1010, 4'b0101, 1'b1, 5'b1_0000, "vec_alt_cin");
        drive(4'b1111, 4'b1111, 1'b1, 5'b1_1111, "vec_max");

        // Full carry ripple and its no-carry counterpart.
        drive(4'b1111, 4'b0000, 1'b1, 5'b1_0000, "ripple_cin1");
        drive(4'b1111, 4'b0000, 1'b0, 5'b0_1111, "ripple_cin0");

        // Back-to-back, new operands every cycle.
        drive(4'h1, 4'h2, 1'b0, 5'b0_0011, "b2b_0");
        drive(4'h7, 4'h8, 1'b1, 5'b1_0000, "b2b_1");
        drive(4'h9, 4'h9, 1'b0, 5'b1_0010, "b2b_2");
        drive(4'h3, 4'h4, 1'b1, 5'b0_1000, "b2b_3");
        drive(4'hC, 4'h3, 1'b0, 5'b0_1111, "b2b_4");
        drive(4'hE, 4'hE, 1'b0, 5'b1_1100, "b2b_5");
        drive(4'h6, 4'hA, 1'b1, 5'b1_0001, "b2b_6");
        drive(4'h2, 4'hD, 1'b0, 5'b0_1111, "b2b_7");

        // Mid-stream reset between edges.
        drive(4'hF, 4'hF, 1'b0, 5'b1_1110, "pre_midreset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("midreset_async", {cout, sum}, 5'b0_0000);
        repeat (2) begin
            @(negedge clk);
            check("midreset_hold", {cout, sum}, 5'b0_0000);
        end
        @(negedge clk);
        a     = 4'h8;
        b     = 4'h9;
        cin   = 1'b1;
        rst_n = 1'b1;
        exp_q.push_back(5'b1_0010);
        name_q.push_back("midreset_resume");
        drive(4'h4, 4'h4, 1'b0, 5'b0_1000, "midreset_next");

        // Exhaustive sweep of every (a,b,cin).
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] e;
            v = 9'(i);
            e = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            drive(v[3:0], v[7:4], v[8], e, "exhaustive");
        end

        // Every pushed expectation must have been consumed.
        @(posedge clk);
        #3;
        check("scoreboard_drain", 5'(exp_q.size()), 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
